// File: rtl/pp_pipeline_accel_ctrl_pkg.sv
// ============================================================================
// pp_pipeline_accel_ctrl_pkg : shared control constants for the loop sequencers
// Revision: 1.0
// ============================================================================
`default_nettype none

package pp_pipeline_accel_ctrl_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_DRAIN = ST_DRAIN,
    S_DONE  = ST_DONE
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/pp_pipeline_accel_run_counter.sv
// ============================================================================
// pp_pipeline_accel_run_counter : up-counter with clear, enable and compare
// Revision: 1.0
// ============================================================================
`default_nettype none

module pp_pipeline_accel_run_counter
  import pp_pipeline_accel_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] cmp_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             eq_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear wins over enable so a new task always starts from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign eq_o  = (cnt_q == cmp_i);

endmodule

`default_nettype wire

// File: rtl/pp_pipeline_accel_loop_run_sequencer.sv
// ============================================================================
// pp_pipeline_accel_loop_run_sequencer : launches a child loop block trip_count
// times per task over ap_start/ap_ready/ap_done, overlapping completions.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pp_pipeline_accel_loop_run_sequencer
  import pp_pipeline_accel_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  output logic             ap_ready,
  output logic             ap_done,
  output logic             ap_idle,
  input  logic             ap_continue,
  input  logic [CNT_W-1:0] trip_count,
  output logic             child_ap_start,
  input  logic             child_ap_ready,
  input  logic             child_ap_done,
  output logic [CNT_W-1:0] run_index,
  output logic             first_run,
  output logic             err
);

  seq_state_e       state_q;
  logic [CNT_W-1:0] trip_q;
  logic             err_q;

  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] done_cnt;
  logic             issue_last;
  logic             done_last;
  logic [CNT_W-1:0] trip_m1;

  logic in_idle, in_issue, in_drain, in_done;
  logic accept, err_now, issue_en, done_en, final_done, cnt_clr, zero_task;

  assign in_idle  = (state_q == S_IDLE);
  assign in_issue = (state_q == S_ISSUE);
  assign in_drain = (state_q == S_DRAIN);
  assign in_done  = (state_q == S_DONE);

  assign trip_m1   = trip_q - CNT_W'(1);
  assign accept    = in_issue && child_ap_ready;
  assign zero_task = in_idle && ap_start && (trip_count == '0);
  assign cnt_clr   = in_idle && ap_start && (trip_count != '0);

  // A completion is only legal against a launch already accepted or accepted
  // in this same cycle; anything beyond that is an over-completion.
  assign err_now = (child_ap_ready && !in_issue)
                || (child_ap_done && (in_idle || in_done))
                || (child_ap_done && (in_issue || in_drain)
                    && (done_cnt == issue_cnt) && !accept);

  assign issue_en   = accept && !err_now;
  assign done_en    = child_ap_done && (in_issue || in_drain) && !err_now;
  assign final_done = done_en && done_last;

  pp_pipeline_accel_run_counter #(.CNT_W(CNT_W)) u_issue_cnt (
    .clk_i   (ap_clk),
    .rst_n_i (ap_rst_n),
    .clr_i   (cnt_clr),
    .en_i    (issue_en),
    .cmp_i   (trip_m1),
    .cnt_o   (issue_cnt),
    .eq_o    (issue_last)
  );

  pp_pipeline_accel_run_counter #(.CNT_W(CNT_W)) u_done_cnt (
    .clk_i   (ap_clk),
    .rst_n_i (ap_rst_n),
    .clr_i   (cnt_clr),
    .en_i    (done_en),
    .cmp_i   (trip_m1),
    .cnt_o   (done_cnt),
    .eq_o    (done_last)
  );

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= S_IDLE;
      trip_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (err_now) begin
        err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (ap_start) begin
            trip_q  <= trip_count;
            state_q <= (trip_count != '0) ? S_ISSUE : S_DONE;
          end
        end
        S_ISSUE: begin
          if (issue_en && issue_last) begin
            state_q <= final_done ? S_DONE : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (final_done) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (ap_continue) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ap_ready       = zero_task || (issue_en && issue_last);
  assign ap_done        = in_done;
  assign ap_idle        = in_idle;
  assign child_ap_start = in_issue;
  assign run_index      = in_issue ? issue_cnt : '0;
  assign first_run      = in_issue && (issue_cnt == '0);
  assign err            = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pp_pipeline_accel_loop_run_sequencer.sv
// ============================================================================
// tb_pp_pipeline_accel_loop_run_sequencer : directed cycle tables per scenario
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pp_pipeline_accel_loop_run_sequencer;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_continue;
  logic [15:0] trip_count;
  logic        child_ap_start;
  logic        child_ap_ready;
  logic        child_ap_done;
  logic [15:0] run_index;
  logic        first_run;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 ap_clk = ~ap_clk;

  pp_pipeline_accel_loop_run_sequencer #(.CNT_W(16)) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .ap_start       (ap_start),
    .ap_ready       (ap_ready),
    .ap_done        (ap_done),
    .ap_idle        (ap_idle),
    .ap_continue    (ap_continue),
    .trip_count     (trip_count),
    .child_ap_start (child_ap_start),
    .child_ap_ready (child_ap_ready),
    .child_ap_done  (child_ap_done),
    .run_index      (run_index),
    .first_run      (first_run),
    .err            (err)
  );

  // Inputs {ap_start, ap_continue, child_ap_ready, child_ap_done}
  // Flags  {child_ap_start, first_run, ap_ready, ap_done, ap_idle, err}

  task automatic test_reset();
    ap_rst_n = 1'b0; ap_start = 0; ap_continue = 0; trip_count = '0;
    child_ap_ready = 0; child_ap_done = 0;
    #3;
    checks++;
    if ({child_ap_start, first_run, ap_ready, ap_done, ap_idle, err} !== 6'b000010) begin
      errors++;
      $display("FAIL reset_flags got %b want %b",
               {child_ap_start, first_run, ap_ready, ap_done, ap_idle, err}, 6'b000010);
    end
    checks++;
    if (run_index !== 16'd0) begin
      errors++; $display("FAIL reset_index got %0d want 0", run_index);
    end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    checks++;
    if (ap_idle !== 1'b1) begin
      errors++; $display("FAIL post_reset_idle got %b want 1", ap_idle);
    end
  endtask

  task automatic test_basic_trip3();
    logic [3:0]  vin  [8] = '{4'b1000, 4'b0010, 4'b0010, 4'b0011,
                              4'b0001, 4'b0001, 4'b0100, 4'b0000};
    logic [5:0]  vexp [8] = '{6'b000010, 6'b110000, 6'b100000, 6'b101000,
                              6'b000000, 6'b000000, 6'b000100, 6'b000010};
    logic [15:0] vidx [8] = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0};
    trip_count = 16'd3;
    for (int c = 0; c < 8; c++) begin
      {ap_start, ap_continue, child_ap_ready, child_ap_done} = vin[c];
      #1;
      checks++;
      if ({child_ap_start, first_run, ap_ready, ap_done, ap_idle, err} !== vexp[c]) begin
        errors++;
        $display("FAIL trip3_flags c%0d got %b want %b", c,
                 {child_ap_start, first_run, ap_ready, ap_done, ap_idle, err}, vexp[c]);
      end
      checks++;
      if (run_index !== vidx[c]) begin
        errors++; $display("FAIL trip3_index c%0d got %0d want %0d", c, run_index, vidx[c]);
      end
      @(posedge ap_clk); #1;
    end
  endtask

  task automatic test_zero_trip();
    logic [3:0] vin  [3] = '{4'b1000, 4'b0100, 4'b0000};
    logic [5:0] vexp [3] = '{6'b001010, 6'b000100, 6'b000010};
    trip_count = 16'd0;
    for (int c = 0; c < 3; c++) begin
      {ap_start, ap_continue, child_ap_ready, child_ap_done} = vin[c];
      #1;
      checks++;
      if ({child_ap_start, first_run, ap_ready, ap_done, ap_idle, err} !== vexp[c]) begin
        errors++;
        $display("FAIL zero_flags c%0d got %b want %b", c,
                 {child_ap_start, first_run, ap_ready, ap_done, ap_idle, err}, vexp[c]);
      end
      @(posedge ap_clk); #1;
    end
  endtask

  task automatic test_done_hold();
    logic [3:0]  vin  [11] = '{4'b1000, 4'b0010, 4'b0011, 4'b0001, 4'b0000, 4'b1000,
                               4'b1000, 4'b0000, 4'b0000, 4'b0100, 4'b0000};
    logic [5:0]  vexp [11] = '{6'b000010, 6'b110000, 6'b101000, 6'b000000, 6'b000100,
                               6'b000100, 6'b000100, 6'b000100, 6'b000100, 6'b000100,
                               6'b000010};
    logic [15:0] vidx [11] = '{16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0,
                               16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    trip_count = 16'd2;
    for (int c = 0; c < 11; c++) begin
      {ap_start, ap_continue, child_ap_ready, child_ap_done} = vin[c];
      #1;
      checks++;
      if ({child_ap_start, first_run, ap_ready, ap_done, ap_idle, err} !== vexp[c]) begin
        errors++;
        $display("FAIL hold_flags c%0d got %b want %b", c,
                 {child_ap_start, first_run, ap_ready, ap_done, ap_idle, err}, vexp[c]);
      end
      checks++;
      if (run_index !== vidx[c]) begin
        errors++; $display("FAIL hold_index c%0d got %0d want %0d", c, run_index, vidx[c]);
      end
      @(posedge ap_clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  vin  [11] = '{4'b1000, 4'b0010, 4'b0000, 4'b0011, 4'b0000, 4'b0011,
                               4'b0000, 4'b0011, 4'b0001, 4'b0100, 4'b0000};
    logic [5:0]  vexp [11] = '{6'b000010, 6'b110000, 6'b100000, 6'b100000, 6'b100000,
                               6'b100000, 6'b100000, 6'b101000, 6'b000000, 6'b000100,
                               6'b000010};
    logic [15:0] vidx [11] = '{16'd0, 16'd0, 16'd1, 16'd1, 16'd2, 16'd2,
                               16'd3, 16'd3, 16'd0, 16'd0, 16'd0};
    trip_count = 16'd4;
    for (int c = 0; c < 11; c++) begin
      {ap_start, ap_continue, child_ap_ready, child_ap_done} = vin[c];
      #1;
      checks++;
      if ({child_ap_start, first_run, ap_ready, ap_done, ap_idle, err} !== vexp[c]) begin
        errors++;
        $display("FAIL toggle_flags c%0d got %b want %b", c,
                 {child_ap_start, first_run, ap_ready, ap_done, ap_idle, err}, vexp[c]);
      end
      checks++;
      if (run_index !== vidx[c]) begin
        errors++; $display("FAIL toggle_index c%0d got %0d want %0d", c, run_index, vidx[c]);
      end
      @(posedge ap_clk); #1;
    end
  endtask

  task automatic test_sticky_err();
    logic [3:0] vin  [6] = '{4'b0001, 4'b1000, 4'b0010, 4'b0001, 4'b0100, 4'b0000};
    logic [5:0] vexp [6] = '{6'b000010, 6'b000011, 6'b111001, 6'b000001,
                             6'b000101, 6'b000011};
    trip_count = 16'd1;
    for (int c = 0; c < 6; c++) begin
      {ap_start, ap_continue, child_ap_ready, child_ap_done} = vin[c];
      #1;
      checks++;
      if ({child_ap_start, first_run, ap_ready, ap_done, ap_idle, err} !== vexp[c]) begin
        errors++;
        $display("FAIL err_flags c%0d got %b want %b", c,
                 {child_ap_start, first_run, ap_ready, ap_done, ap_idle, err}, vexp[c]);
      end
      @(posedge ap_clk); #1;
    end
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL err_clear got %b want 0", err);
    end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
  endtask

  task automatic test_reset_mid_task();
    logic [3:0]  vin  [5] = '{4'b1000, 4'b0010, 4'b0001, 4'b0100, 4'b0000};
    logic [5:0]  vexp [5] = '{6'b000010, 6'b111000, 6'b000000, 6'b000100, 6'b000010};
    trip_count = 16'd5;
    for (int c = 0; c < 4; c++) begin
      {ap_start, ap_continue, child_ap_ready, child_ap_done} = (c == 0) ? 4'b1000 : 4'b0010;
      #1;
      checks++;
      if (child_ap_start !== (c != 0) || run_index !== ((c == 0) ? 16'd0 : 16'(c - 1))) begin
        errors++;
        $display("FAIL abort_pre c%0d got start %b idx %0d", c, child_ap_start, run_index);
      end
      if (c < 3) begin
        @(posedge ap_clk); #1;
      end
    end
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if ({child_ap_start, first_run, ap_ready, ap_done, ap_idle, err} !== 6'b000010
        || run_index !== 16'd0) begin
      errors++;
      $display("FAIL abort_now got %b idx %0d want 000010 idx 0",
               {child_ap_start, first_run, ap_ready, ap_done, ap_idle, err}, run_index);
    end
    {ap_start, ap_continue, child_ap_ready, child_ap_done} = 4'b0000;
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    trip_count = 16'd1;
    for (int c = 0; c < 5; c++) begin
      {ap_start, ap_continue, child_ap_ready, child_ap_done} = vin[c];
      #1;
      checks++;
      if ({child_ap_start, first_run, ap_ready, ap_done, ap_idle, err} !== vexp[c]) begin
        errors++;
        $display("FAIL abort_after c%0d got %b want %b", c,
                 {child_ap_start, first_run, ap_ready, ap_done, ap_idle, err}, vexp[c]);
      end
      checks++;
      if (run_index !== 16'd0) begin
        errors++; $display("FAIL abort_index c%0d got %0d want 0", c, run_index);
      end
      @(posedge ap_clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic_trip3();
    test_zero_trip();
    test_done_hold();
    test_back_to_back();
    test_sticky_err();
    test_reset_mid_task();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
